// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch / load-store memory port arbiter:
// FSM state, requester select, DataCtrl codes and access-size decode.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_FETCH = 2'd1,
    SEL_DATA  = 2'd2
  } req_sel_e;

  // DataCtrl encoding shared with control_unit.
  localparam logic [2:0] DC_WORD  = 3'b000;
  localparam logic [2:0] DC_HALF  = 3'b001;
  localparam logic [2:0] DC_BYTE  = 3'b010;
  localparam logic [2:0] DC_HALFU = 3'b101;
  localparam logic [2:0] DC_BYTEU = 3'b110;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Unused codes (011, 100, 111) fall back to a word access.
  function automatic acc_size_e decode_size(input logic [2:0] ctrl);
    acc_size_e size;
    case (ctrl)
      DC_HALF, DC_HALFU: size = SZ_HALF;
      DC_BYTE, DC_BYTEU: size = SZ_BYTE;
      default:           size = SZ_WORD;
    endcase
    return size;
  endfunction

  function automatic logic is_unsigned(input logic [2:0] ctrl);
    return (ctrl == DC_HALFU) || (ctrl == DC_BYTEU);
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Purely combinational sub-word alignment: byte enables and lane-replicated
// store data, shifted and sign/zero-extended load data, misalignment flag.
module load_store_align
  import mem_arb_pkg::*;
(
  input  logic [2:0]  ctrl_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  acc_size_e   size;
  logic [31:0] shifted;

  // Decode the access size into lane enables, store data, load data and the trap.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    size         = decode_size(ctrl_i);
    shifted      = rdata_i >> {addr_lo_i, 3'b000};
    be_o         = 4'b1111;
    wdata_o      = wdata_i;
    rdata_o      = shifted;
    misaligned_o = 1'b0;
    case (size)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = is_unsigned(ctrl_i) ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = is_unsigned(ctrl_i) ? {16'b0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
        misaligned_o = addr_lo_i[0];
      end
      default: begin
        misaligned_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and
// load/store. One transaction at a time over req/ready/rvalid; data wins
// unless fetch has been starved for STARVE_LIMIT consecutive data grants.
// Optional build macro MEM_ARB_PERF_EN adds per-requester wait-cycle counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_ctrl,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_if_wait,
  output logic [31:0]           perf_d_wait
`endif
);

  localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e            state_q;
  req_sel_e              owner_q;
  req_sel_e              sel;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            ctrl_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;
  logic [CNT_W-1:0]      starve_q;
  logic [CNT_W-1:0]      starve_d;

  logic [2:0]            al_ctrl;
  logic [1:0]            al_addr_lo;
  logic [3:0]            al_be;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [DATA_WIDTH-1:0] al_rdata;
  logic                  al_mis;

  // In IDLE the aligner sees the live request; afterwards the latched one,
  // so the same instance also extends the load data in WAIT.
  assign al_ctrl    = (state_q == IDLE) ? d_ctrl      : ctrl_q;
  assign al_addr_lo = (state_q == IDLE) ? d_addr[1:0] : addr_q[1:0];

  load_store_align u_align (
    .ctrl_i       (al_ctrl),
    .addr_lo_i    (al_addr_lo),
    .wdata_i      (d_wdata),
    .rdata_i      (mem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata),
    .misaligned_o (al_mis)
  );

  // Pick the requester to grant this IDLE cycle; fetch jumps the queue when starved.
  always_comb begin
    sel = SEL_NONE;
    if (!rst && (state_q == IDLE)) begin
      if (if_req && (starve_q == STARVE_MAX)) begin
        sel = SEL_FETCH;
      end else if (d_req) begin
        sel = SEL_DATA;
      end else if (if_req) begin
        sel = SEL_FETCH;
      end
    end
  end

  // Starvation count: data grants taken while fetch waits, saturating.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!if_req || (sel == SEL_FETCH)) begin
        starve_d = '0;
      end else if ((sel == SEL_DATA) && (starve_q != STARVE_MAX)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Transaction FSM: grant and latch, issue until accepted, await data, respond.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this block is all control/datapath flops, so every one is reset to keep outputs at 0 in reset.
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= SEL_NONE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      ctrl_q     <= DC_WORD;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel == SEL_FETCH) begin
            owner_q <= SEL_FETCH;
            addr_q  <= if_addr;
            we_q    <= 1'b0;
            be_q    <= 4'b1111;
            wdata_q <= '0;
            ctrl_q  <= DC_WORD;
            err_q   <= 1'b0;
            state_q <= ISSUE;
          end else if (sel == SEL_DATA) begin
            owner_q <= SEL_DATA;
            addr_q  <= d_addr;
            we_q    <= d_we;
            be_q    <= d_we ? al_be : 4'b1111;
            wdata_q <= d_we ? al_wdata : '0;
            ctrl_q  <= d_ctrl;
            err_q   <= al_mis;
            if (al_mis) begin
              // Trapped access never reaches memory and returns zero data.
              d_rdata_q <= '0;
              state_q   <= RESP;
            end else begin
              state_q   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (owner_q == SEL_FETCH) begin
              if_rdata_q <= mem_rdata;
            end else begin
              d_rdata_q  <= we_q ? '0 : al_rdata;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_gnt    = (sel == SEL_FETCH);
  assign d_gnt     = (sel == SEL_DATA);
  assign if_rvalid = (state_q == RESP) && (owner_q == SEL_FETCH);
  assign d_rvalid  = (state_q == RESP) && (owner_q == SEL_DATA);
  assign d_err     = d_rvalid && err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

  assign stall = !rst && ((state_q == ISSUE) || (state_q == WAIT) ||
                          ((state_q == IDLE) && (if_req || d_req)));

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_wait_q;
  logic [31:0] perf_d_wait_q;

  // Count cycles each requester holds req without being granted; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_wait_q <= '0;
      perf_d_wait_q  <= '0;
    end else begin
      if (if_req && !if_gnt) begin
        perf_if_wait_q <= perf_if_wait_q + 32'd1;
      end
      if (d_req && !d_gnt) begin
        perf_d_wait_q  <= perf_d_wait_q + 32'd1;
      end
    end
  end

  assign perf_if_wait = perf_if_wait_q;
  assign perf_d_wait  = perf_d_wait_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single-ported unified instruction/data memory between the fetch stage and the load/store stage of the RISC-V core.
- Sequences one transaction at a time over a req/ready/rvalid memory handshake.
- Data accesses have priority, with a starvation guard for fetch.
- Generates byte enables and write-data replication for sub-word stores, sign- or zero-extends sub-word loads, traps misaligned accesses, and drives the pipeline stall.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, memory word width; only 32 is supported.
- STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending before fetch is forced to win.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_WIDTH  fetch byte address; word-aligned by contract.
- if_gnt  out  1  one-cycle pulse: fetch request latched.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_WIDTH  fetched instruction word.
- d_req  in  1  load/store request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_ctrl  in  3  000 word, 001 half, 010 byte, 101 half unsigned, 110 byte unsigned.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  DATA_WIDTH  store data, right-aligned.
- d_gnt  out  1  one-cycle pulse: data request latched.
- d_rvalid  out  1  one-cycle pulse: load data valid or store complete.
- d_rdata  out  DATA_WIDTH  extended load data; 0 for stores.
- d_err  out  1  pulses together with d_rvalid on a misaligned access.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 00).
- mem_be  out  4  byte enables.
- mem_wdata  out  DATA_WIDTH  lane-replicated write data.
- mem_ready  in  1  memory accepts the request in this cycle.
- mem_rvalid  in  1  read data valid or write acknowledge.
- mem_rdata  in  DATA_WIDTH  raw memory word.
- stall  out  1  freeze the pipeline.

Behaviour:
- Reset: async rst forces state IDLE, starvation counter 0, and every output 0. Any in-flight response is discarded (memory is reset by the same rst).
- States and transitions:
  - IDLE: selects a requester, latches its address/we/be/wdata, pulses its gnt, and goes to ISSUE. Selection is d_req unless the starvation count equals STARVE_LIMIT and if_req is high.
  - ISSUE: mem_req=1 with the latched fields. When mem_ready=1, go to WAIT; the request is held unchanged until then.
  - WAIT: on mem_rvalid, capture the data and go to RESP.
  - RESP: pulse if_rvalid or d_rvalid with the registered data, then return to IDLE. A new grant can occur in the next IDLE cycle.
- Minimum latency: request seen in cycle N → gnt in N, mem_req in N+1. With mem_ready at N+1 and mem_rvalid at N+2, rvalid is pulsed at N+3.
- Starvation counter:
  - Increments on each data grant while if_req is high.
  - Clears on every fetch grant and whenever if_req is low in IDLE.
  - Saturates at STARVE_LIMIT.
- Byte enables and write data:
  - Byte store: mem_be = 1 << addr[1:0]; the byte is replicated to all four lanes.
  - Half store: mem_be = 0011 (addr[1]=0) or 1100 (addr[1]=1); the half is replicated.
  - Word store: mem_be = 1111.
  - Fetches and loads: mem_be = 1111.
- d_ctrl decoding:
  - Stores with 101/110 are treated as half/byte.
  - Codes 011, 100 and 111 are treated as word.
- Load data: the word is shifted right by addr[1:0]*8 and then sign-extended (000/001/010) or zero-extended (101/110).
- Misaligned access (half with addr[0]=1, or word with addr[1:0]≠00):
  - d_gnt is still pulsed.
  - No memory transaction is issued.
  - State goes to RESP directly and d_rvalid and d_err are pulsed in the next cycle, with d_rdata = 0.
- stall: 1 in ISSUE and WAIT, and in IDLE when if_req or d_req is high; 0 in RESP and in IDLE with no request.
- Requests arriving while the block is busy are ignored until IDLE; requesters hold req.
- mem_rvalid outside WAIT is ignored.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined: adds outputs perf_if_wait [31:0] and perf_d_wait [31:0]. Each counts cycles where the respective req is high and its gnt is low. They are cleared by rst and wrap at 2^32.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - DataCtrl code localparams (DC_WORD, DC_HALF, DC_BYTE, DC_HALFU, DC_BYTEU), shared with control_unit;
  - the requester-select enum.
- Sub-module load_store_align is purely combinational: d_ctrl + addr[1:0] + wdata/rdata → be, replicated wdata, extended rdata, misaligned flag.

Test Plan:
- Fetch only, addr 0x0000_0010, mem_ready immediate, rvalid after 1 cycle with rdata 0x0000_0013 → if_gnt at N, mem_req N+1, if_rvalid at N+3 with 0x0000_0013, stall low at N+3.
- Simultaneous if_req and d_req (lb, addr 0x103, mem word 0x80FF_FF00) → d_gnt first, d_rdata=0xFFFF_FF80; if_gnt in the following IDLE.
- sh to addr 0x202 with wdata 0x0000_BEEF → mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1, d_rvalid with d_rdata=0.
- lw to addr 0x101 → d_err and d_rvalid pulse the cycle after d_gnt, mem_req never asserted.
- d_req held continuously with if_req high → after 4 data grants the 5th grant goes to fetch; mem_ready held low 3 cycles keeps mem_req and mem_addr stable.
- rst asserted during WAIT → all outputs 0 immediately, late mem_rvalid ignored, no rvalid pulse.
